// File: rtl/memory_turn_fsm.sv
// -----------------------------------------------------------------------------
// memory_turn_fsm
//
// Turn, score and end-of-game controller for the memory card game.
// It supports 2..4 players and a configurable number of pairs. It sequences
// turns, compares the two flipped cards, holds the reveal for SHOW_CYCLES,
// awards points and reports the winner, or a tie, once every pair is found.
//
// Ports:
//   clk, rst     rising-edge clock; synchronous active-high reset
//   start        begins a new game from IDLE or OVER
//   sel_valid    card-select pulse (sampled in FIRST/SECOND only)
//   sel_idx      index of the selected card
//   sel_val      symbol of the selected card
//   state        IDLE=0 FIRST=1 SECOND=2 CMP=3 SHOW=4 OVER=5
//   player       player whose turn it is
//   scores       per-player score, player p at [p*SW +: SW]
//   pair_found   high during the CMP cycle of a matching pair
//   flip_back    one-cycle pulse: hide the unmatched card(s)
//   timeout      one-cycle pulse: the turn expired
//   game_over    high while in OVER
//   winner       lowest-indexed player holding the top score (OVER only)
//   tie          two or more players share the top score (OVER only)
//
// Configuration macro: TURN_TIMEOUT_EN
//   defined   -> per-selection idle timer with timeout/turn-forfeit
//   undefined -> no timer; FIRST/SECOND wait indefinitely, timeout = 0
// -----------------------------------------------------------------------------
module memory_turn_fsm #(
  parameter  int NUM_PLAYERS = 2,
  parameter  int NUM_PAIRS   = 8,
  parameter  int IDX_W       = 4,
  parameter  int VAL_W       = 3,
  parameter  int SHOW_CYCLES = 4,
  parameter  int TURN_CYCLES = 1000,
  localparam int PW          = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int SW          = $clog2(NUM_PAIRS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sel_valid,
  input  logic [IDX_W-1:0]          sel_idx,
  input  logic [VAL_W-1:0]          sel_val,
  output logic [2:0]                state,
  output logic [PW-1:0]             player,
  output logic [NUM_PLAYERS*SW-1:0] scores,
  output logic                      pair_found,
  output logic                      flip_back,
  output logic                      timeout,
  output logic                      game_over,
  output logic [PW-1:0]             winner,
  output logic                      tie
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FIRST  = 3'd1;
  localparam logic [2:0] S_SECOND = 3'd2;
  localparam logic [2:0] S_CMP    = 3'd3;
  localparam logic [2:0] S_SHOW   = 3'd4;
  localparam logic [2:0] S_OVER   = 3'd5;

  localparam int CW = $clog2(SHOW_CYCLES + 1);

  logic [2:0]                state_q,     state_d;
  logic [PW-1:0]             player_q,    player_d;
  logic [NUM_PLAYERS*SW-1:0] scores_q,    scores_d;
  logic [SW-1:0]             pairs_q,     pairs_d;
  logic [IDX_W-1:0]          idx1_q,      idx1_d;
  logic [VAL_W-1:0]          val1_q,      val1_d;
  logic [VAL_W-1:0]          val2_q,      val2_d;
  logic [CW-1:0]             show_cnt_q,  show_cnt_d;
  logic                      match_q,     match_d;
  logic                      flip_back_q, flip_back_d;
  logic                      timeout_q,   timeout_d;

  logic          in_select;
  logic          accept;
  logic          expire;
  logic [PW-1:0] next_player;

  assign in_select = (state_q == S_FIRST) || (state_q == S_SECOND);

  // A repeat of the first card in SECOND is not an accepted select.
  assign accept = sel_valid &&
                  ((state_q == S_FIRST) ||
                   ((state_q == S_SECOND) && (sel_idx != idx1_q)));

  assign next_player = (player_q == PW'(NUM_PLAYERS - 1)) ? '0 : player_q + 1'b1;

`ifdef TURN_TIMEOUT_EN
  localparam int TW = $clog2(TURN_CYCLES + 1);

  logic [TW-1:0] timer_q, timer_d;

  // timer_q holds the idle cycles already spent; the cycle in which it reads
  // TURN_CYCLES-1 without an accepted select is the last allowed one. An
  // accepted select in that same cycle takes priority over the expiry.
  assign expire = in_select && !accept && (timer_q == TW'(TURN_CYCLES - 1));

  always_comb begin
    timer_d = timer_q + 1'b1;
    if (!in_select || accept || expire) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic unused_turn_cycles;

  assign expire             = 1'b0;
  assign unused_turn_cycles = (TURN_CYCLES != 0);
`endif

  always_comb begin
    state_d     = state_q;
    player_d    = player_q;
    scores_d    = scores_q;
    pairs_d     = pairs_q;
    idx1_d      = idx1_q;
    val1_d      = val1_q;
    val2_d      = val2_q;
    show_cnt_d  = show_cnt_q;
    match_d     = match_q;
    flip_back_d = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          scores_d = '0;
          pairs_d  = '0;
          player_d = '0;
          state_d  = S_FIRST;
        end
      end

      S_FIRST: begin
        if (accept) begin
          idx1_d  = sel_idx;
          val1_d  = sel_val;
          state_d = S_SECOND;
        end else if (expire) begin
          timeout_d = 1'b1;
          player_d  = next_player;
        end
      end

      S_SECOND: begin
        if (accept) begin
          val2_d  = sel_val;
          state_d = S_CMP;
        end else if (expire) begin
          timeout_d   = 1'b1;
          flip_back_d = 1'b1;
          player_d    = next_player;
          state_d     = S_FIRST;
        end
      end

      S_CMP: begin
        match_d    = (val1_q == val2_q);
        show_cnt_d = '0;
        state_d    = S_SHOW;
        if (val1_q == val2_q) begin
          scores_d[player_q*SW +: SW] = scores_q[player_q*SW +: SW] + 1'b1;
          pairs_d                     = pairs_q + 1'b1;
        end
      end

      S_SHOW: begin
        if (show_cnt_q == CW'(SHOW_CYCLES - 1)) begin
          if (match_q) begin
            state_d = (pairs_q == SW'(NUM_PAIRS)) ? S_OVER : S_FIRST;
          end else begin
            flip_back_d = 1'b1;
            player_d    = next_player;
            state_d     = S_FIRST;
          end
        end else begin
          show_cnt_d = show_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      player_q    <= '0;
      scores_q    <= '0;
      pairs_q     <= '0;
      idx1_q      <= '0;
      val1_q      <= '0;
      val2_q      <= '0;
      show_cnt_q  <= '0;
      match_q     <= 1'b0;
      flip_back_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      player_q    <= player_d;
      scores_q    <= scores_d;
      pairs_q     <= pairs_d;
      idx1_q      <= idx1_d;
      val1_q      <= val1_d;
      val2_q      <= val2_d;
      show_cnt_q  <= show_cnt_d;
      match_q     <= match_d;
      flip_back_q <= flip_back_d;
      timeout_q   <= timeout_d;
    end
  end

  // Top-score search: a strictly greater score takes over, so the earliest
  // player holding the maximum is kept; equal scores only bump the count.
  logic [PW-1:0] best;
  logic [SW-1:0] best_score;
  logic [2:0]    best_count;
  logic [SW-1:0] cur_score;

  always_comb begin
    best       = '0;
    best_score = scores_q[SW-1:0];
    best_count = 3'd1;
    cur_score  = '0;
    for (int unsigned i = 1; i < NUM_PLAYERS; i++) begin
      cur_score = scores_q[i*SW +: SW];
      if (cur_score > best_score) begin
        best       = PW'(i);
        best_score = cur_score;
        best_count = 3'd1;
      end else if (cur_score == best_score) begin
        best_count = best_count + 3'd1;
      end
    end
  end

  assign state      = state_q;
  assign player     = player_q;
  assign scores     = scores_q;
  assign pair_found = (state_q == S_CMP) && (val1_q == val2_q);
  assign flip_back  = flip_back_q;
  assign timeout    = timeout_q;
  assign game_over  = (state_q == S_OVER);
  assign winner     = (state_q == S_OVER) ? best : '0;
  assign tie        = (state_q == S_OVER) && (best_count >= 3'd2);

endmodule

// File: tb/tb_memory_turn_fsm.sv
// -----------------------------------------------------------------------------
// tb_memory_turn_fsm
//
// Self-checking bench for memory_turn_fsm with three players, two pairs,
// a two-cycle reveal and a five-cycle turn limit. A game-level reference
// model is stepped on every clock; a directed vector table, hand-written
// corner-case sequences and a randomized run are compared against it and
// against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_memory_turn_fsm;

  localparam int NP     = 3;
  localparam int NPAIRS = 2;
  localparam int SHOWC  = 2;
  localparam int TC     = 5;
  localparam int SW     = 2;
  localparam int PW     = 2;

`ifdef TURN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 sel_valid;
  logic [3:0]           sel_idx;
  logic [2:0]           sel_val;
  logic [2:0]           state;
  logic [PW-1:0]        player;
  logic [NP*SW-1:0]     scores;
  logic                 pair_found;
  logic                 flip_back;
  logic                 timeout;
  logic                 game_over;
  logic [PW-1:0]        winner;
  logic                 tie;

  memory_turn_fsm #(
    .NUM_PLAYERS (NP),
    .NUM_PAIRS   (NPAIRS),
    .IDX_W       (4),
    .VAL_W       (3),
    .SHOW_CYCLES (SHOWC),
    .TURN_CYCLES (TC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sel_valid  (sel_valid),
    .sel_idx    (sel_idx),
    .sel_val    (sel_val),
    .state      (state),
    .player     (player),
    .scores     (scores),
    .pair_found (pair_found),
    .flip_back  (flip_back),
    .timeout    (timeout),
    .game_over  (game_over),
    .winner     (winner),
    .tie        (tie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Game-level reference model (phase numbers follow the state output codes)
  // ---------------------------------------------------------------------------
  int m_st, m_pl, m_pairs, m_i1, m_v1, m_v2, m_show, m_idle;
  int m_score[NP];
  bit m_match, m_fb, m_to;

  task automatic model_step(input bit r, input bit s, input bit sv, input int i, input int v);
    m_fb = 0;
    m_to = 0;
    if (r) begin
      m_st = 0; m_pl = 0; m_pairs = 0; m_idle = 0; m_match = 0;
      foreach (m_score[p]) m_score[p] = 0;
      return;
    end
    case (m_st)
      0, 5: if (s) begin
        foreach (m_score[p]) m_score[p] = 0;
        m_pairs = 0; m_pl = 0; m_idle = 0; m_st = 1;
      end
      1: if (sv) begin
        m_i1 = i; m_v1 = v; m_idle = 0; m_st = 2;
      end else if (TO_EN) begin
        m_idle++;
        if (m_idle == TC) begin
          m_to = 1; m_pl = (m_pl + 1) % NP; m_idle = 0;
        end
      end
      2: if (sv && i != m_i1) begin
        m_v2 = v; m_st = 3;
      end else if (TO_EN) begin
        m_idle++;
        if (m_idle == TC) begin
          m_to = 1; m_fb = 1; m_pl = (m_pl + 1) % NP; m_idle = 0; m_st = 1;
        end
      end
      3: begin
        m_match = (m_v1 == m_v2);
        if (m_match) begin
          m_score[m_pl]++;
          m_pairs++;
        end
        m_show = SHOWC;
        m_st = 4;
      end
      4: begin
        m_show--;
        if (m_show == 0) begin
          m_idle = 0;
          if (m_match) m_st = (m_pairs == NPAIRS) ? 5 : 1;
          else begin
            m_fb = 1; m_pl = (m_pl + 1) % NP; m_st = 1;
          end
        end
      end
      default: m_st = 0;
    endcase
  endtask

  function automatic logic [31:0] model_scores();
    logic [31:0] f = 0;
    for (int p = 0; p < NP; p++) f |= 32'(m_score[p]) << (p * SW);
    return f;
  endfunction

  function automatic int model_winner();
    int best = 0;
    for (int p = 1; p < NP; p++) if (m_score[p] > m_score[best]) best = p;
    return (m_st == 5) ? best : 0;
  endfunction

  function automatic bit model_tie();
    int mx = 0, n = 0;
    foreach (m_score[p]) if (m_score[p] > mx) mx = m_score[p];
    foreach (m_score[p]) if (m_score[p] == mx) n++;
    return (m_st == 5) && (n >= 2);
  endfunction

  // One clock: drive inputs, advance model with the same inputs, then compare
  // every output against the model just after the edge.
  task automatic tick(input bit r, input bit s, input bit sv, input int i, input int v);
    rst = r; start = s; sel_valid = sv; sel_idx = 4'(i); sel_val = 3'(v);
    @(posedge clk);
    model_step(r, s, sv, i, v);
    #1;
    check("model_state",  32'(state),      32'(m_st));
    check("model_player", 32'(player),     32'(m_pl));
    check("model_scores", 32'(scores),     model_scores());
    check("model_pf",     32'(pair_found), 32'((m_st == 3) && (m_v1 == m_v2)));
    check("model_fb",     32'(flip_back),  32'(m_fb));
    check("model_to",     32'(timeout),    32'(m_to));
    check("model_over",   32'(game_over),  32'(m_st == 5));
    check("model_winner", 32'(winner),     32'(model_winner()));
    check("model_tie",    32'(tie),        32'(model_tie()));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0);
  endtask

  // Two selects followed by the compare and reveal cycles.
  task automatic do_turn(input int i1, input int v1, input int i2, input int v2);
    tick(0, 0, 1, i1, v1);
    tick(0, 0, 1, i2, v2);
    idle(1 + SHOWC);
  endtask

  typedef struct {
    bit   r, s, sv;
    int   i, v;
    int   st, pl;
    logic [5:0] sc;
    bit   pf, fb;
    int   win;
    bit   tie;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, bit sv, int i, int v, int st, int pl,
                              logic [5:0] sc, bit pf, bit fb, int win, bit t);
    vec_t x;
    x.r = r; x.s = s; x.sv = sv; x.i = i; x.v = v; x.st = st; x.pl = pl;
    x.sc = sc; x.pf = pf; x.fb = fb; x.win = win; x.tie = t;
    return x;
  endfunction

  vec_t tbl[20];

  initial begin
    rst = 1'b1; start = 1'b0; sel_valid = 1'b0; sel_idx = '0; sel_val = '0;

    //            r s sv i v   st pl  scores  pf fb win tie
    tbl[0]  = mk(1,0,0, 0,0,  0, 0, 6'b000000, 0,0, 0,0); // reset
    tbl[1]  = mk(0,0,1, 1,1,  0, 0, 6'b000000, 0,0, 0,0); // select in IDLE ignored
    tbl[2]  = mk(0,1,0, 0,0,  1, 0, 6'b000000, 0,0, 0,0); // start
    tbl[3]  = mk(0,1,0, 0,0,  1, 0, 6'b000000, 0,0, 0,0); // start in FIRST ignored
    tbl[4]  = mk(0,0,1, 0,5,  2, 0, 6'b000000, 0,0, 0,0);
    tbl[5]  = mk(0,0,1, 3,5,  3, 0, 6'b000000, 1,0, 0,0); // match in CMP
    tbl[6]  = mk(0,0,0, 0,0,  4, 0, 6'b000001, 0,0, 0,0);
    tbl[7]  = mk(0,0,0, 0,0,  4, 0, 6'b000001, 0,0, 0,0);
    tbl[8]  = mk(0,0,0, 0,0,  1, 0, 6'b000001, 0,0, 0,0); // same player keeps turn
    tbl[9]  = mk(0,0,1, 1,2,  2, 0, 6'b000001, 0,0, 0,0);
    tbl[10] = mk(0,0,1, 4,6,  3, 0, 6'b000001, 0,0, 0,0); // mismatch
    tbl[11] = mk(0,0,0, 0,0,  4, 0, 6'b000001, 0,0, 0,0);
    tbl[12] = mk(0,0,0, 0,0,  4, 0, 6'b000001, 0,0, 0,0);
    tbl[13] = mk(0,0,0, 0,0,  1, 1, 6'b000001, 0,1, 0,0); // flip_back + rotate
    tbl[14] = mk(0,0,1, 7,1,  2, 1, 6'b000001, 0,0, 0,0);
    tbl[15] = mk(0,0,1, 7,1,  2, 1, 6'b000001, 0,0, 0,0); // duplicate ignored
    tbl[16] = mk(0,0,1, 2,1,  3, 1, 6'b000001, 1,0, 0,0);
    tbl[17] = mk(0,0,0, 0,0,  4, 1, 6'b000101, 0,0, 0,0);
    tbl[18] = mk(0,0,0, 0,0,  4, 1, 6'b000101, 0,0, 0,0);
    tbl[19] = mk(0,0,0, 0,0,  5, 1, 6'b000101, 0,0, 0,1); // 1/1/0 -> tie, winner 0

    for (int k = 0; k < 20; k++) begin
      tick(tbl[k].r, tbl[k].s, tbl[k].sv, tbl[k].i, tbl[k].v);
      check("tbl_state",  32'(state),      32'(tbl[k].st));
      check("tbl_player", 32'(player),     32'(tbl[k].pl));
      check("tbl_scores", 32'(scores),     32'(tbl[k].sc));
      check("tbl_pf",     32'(pair_found), 32'(tbl[k].pf));
      check("tbl_fb",     32'(flip_back),  32'(tbl[k].fb));
      check("tbl_winner", 32'(winner),     32'(tbl[k].win));
      check("tbl_tie",    32'(tie),        32'(tbl[k].tie));
    end

    // Rotation 0->1->2->0, then a 1/0/1 finish.
    tick(0, 1, 0, 0, 0);
    check("restart_state",  32'(state),  32'd1);
    check("restart_scores", 32'(scores), 32'd0);
    do_turn(0, 0, 1, 1); check("rot_p1", 32'(player), 32'd1);
    do_turn(2, 0, 3, 1); check("rot_p2", 32'(player), 32'd2);
    do_turn(4, 0, 5, 1); check("rot_wrap", 32'(player), 32'd0);
    do_turn(0, 1, 1, 1); check("keep_turn", 32'(player), 32'd0);
    do_turn(2, 0, 3, 1);
    do_turn(4, 0, 5, 1);
    do_turn(6, 1, 7, 1);
    check("tie_state",  32'(state),     32'd5);
    check("tie_over",   32'(game_over), 32'd1);
    check("tie_scores", 32'(scores),    32'b010001);
    check("tie_winner", 32'(winner),    32'd0);
    check("tie_flag",   32'(tie),       32'd1);

    // 0/2/0 finish.
    tick(0, 1, 0, 0, 0);
    do_turn(0, 0, 1, 1);
    do_turn(2, 1, 3, 1);
    do_turn(4, 0, 5, 0);
    check("win_state",  32'(state),  32'd5);
    check("win_scores", 32'(scores), 32'b001000);
    check("win_winner", 32'(winner), 32'd1);
    check("win_tie",    32'(tie),    32'd0);

    tick(0, 1, 0, 0, 0);
`ifdef TURN_TIMEOUT_EN
    // Expiry in SECOND after five idle cycles.
    tick(0, 0, 1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      tick(0, 0, 0, 0, 0);
      check("to_wait_state", 32'(state),   32'd2);
      check("to_wait_to",    32'(timeout), 32'd0);
    end
    tick(0, 0, 0, 0, 0);
    check("to_state",  32'(state),     32'd1);
    check("to_pulse",  32'(timeout),   32'd1);
    check("to_fb",     32'(flip_back), 32'd1);
    check("to_player", 32'(player),    32'd1);
    tick(0, 0, 0, 0, 0);
    check("to_one_cycle", 32'(timeout), 32'd0);
    // Select on the fifth cycle wins over expiry.
    tick(0, 0, 1, 2, 0);
    idle(4);
    tick(0, 0, 1, 3, 1);
    check("to_race_state", 32'(state),   32'd3);
    check("to_race_to",    32'(timeout), 32'd0);
    idle(1 + SHOWC);
    check("to_race_player", 32'(player), 32'd2);
    // Expiry in FIRST: no card to hide.
    idle(TC);
    check("to_first_pulse",  32'(timeout),   32'd1);
    check("to_first_fb",     32'(flip_back), 32'd0);
    check("to_first_player", 32'(player),    32'd0);
`else
    // Without the timer, FIRST/SECOND wait indefinitely.
    tick(0, 0, 1, 1, 0);
    idle(3 * TC);
    check("notimer_state",  32'(state),   32'd2);
    check("notimer_to",     32'(timeout), 32'd0);
    check("notimer_player", 32'(player),  32'd0);
    tick(0, 0, 1, 2, 1);
    idle(1 + SHOWC);
`endif

    // Reset in the middle of SHOW.
    tick(0, 0, 1, 8, 2);
    tick(0, 0, 1, 9, 2);
    tick(0, 0, 0, 0, 0);
    check("rst_pre_state", 32'(state), 32'd4);
    tick(1, 0, 0, 0, 0);
    check("rst_state",  32'(state),  32'd0);
    check("rst_scores", 32'(scores), 32'd0);
    check("rst_player", 32'(player), 32'd0);
    check("rst_pf",     32'(pair_found), 32'd0);
    tick(0, 0, 1, 2, 3);
    check("rst_sel_ignored", 32'(state), 32'd0);

    // Randomized play against the model.
    for (int c = 0; c < 4000; c++) begin
      bit r, s, sv;
      r  = ($urandom_range(0, 199) == 0);
      s  = (m_st == 0 || m_st == 5) ? ($urandom_range(0, 3) == 0)
                                    : ($urandom_range(0, 15) == 0);
      sv = ((c / 500) % 2 == 1) ? ($urandom_range(0, 1) == 1)
                                : ($urandom_range(0, 7) == 0);
      tick(r, s, sv, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
